lfsr_period_monitor: RTL

Downstream consumer of the Fibonacci LFSR stage: samples the LFSR's value/valid stream once per LFSR step. It captures the first sampled state as a seed and counts steps until that state recurs. It then reports the measured period and whether it is maximal-length (2^length − 1). The top level uses it as an on-chip self-check of the tap masks, reading results out over the output pins.

---
 rtl/lfsr_period_monitor.sv | 133 +++++++++++++
 1 files changed

// File: rtl/lfsr_period_monitor.sv
// lfsr_period_monitor: measures the recurrence period of a sampled LFSR stream
// and flags maximal-length sequences. It captures the first sampled state as the
// seed and counts LFSR steps until that masked state is seen again.
// Optional build macro: LFSR_PERIOD_TIMEOUT_EN makes a measurement give up with
// error=1 once 2^len steps pass without a seed match.
module lfsr_period_monitor #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           lfsr_length,
  input  logic                 lfsr_step,
  input  logic [WIDTH-1:0]     lfsr_value,
  input  logic                 lfsr_valid,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 maximal,
  output logic                 error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  logic [3:0]           len_q;
  logic [WIDTH-1:0]     seed_q;
  logic [CNT_WIDTH-1:0] count_q;

  logic [WIDTH-1:0]     mask_c;
  logic [WIDTH-1:0]     masked_c;
  logic [CNT_WIDTH-1:0] count_inc_c;
  logic                 step_bad_c;
  logic                 match_c;
  logic                 maximal_c;
  logic                 timeout_c;

  // Masked compare value, saturating step count and the completion conditions
  always_comb begin
    mask_c      = (WIDTH'(1) << len_q) - WIDTH'(1);
    masked_c    = lfsr_value & mask_c;
    count_inc_c = (&count_q) ? count_q : count_q + CNT_WIDTH'(1);
    step_bad_c  = !lfsr_valid || (masked_c == '0);
    match_c     = (masked_c == seed_q);
    maximal_c   = (count_inc_c == CNT_WIDTH'(mask_c));
`ifdef LFSR_PERIOD_TIMEOUT_EN
    timeout_c   = (count_inc_c == (CNT_WIDTH'(1) << len_q));
`else
    timeout_c   = 1'b0;
`endif
  end

  // Measurement FSM with registered status/result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      len_q   <= '0;
      seed_q  <= '0;
      count_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      period  <= '0;
      maximal <= 1'b0;
      error   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= ARM;
            len_q   <= lfsr_length;
            count_q <= '0;
            period  <= '0;
            maximal <= 1'b0;
            error   <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        ARM: begin
          if (len_q < 4'd2) begin
            state <= DONE;
            error <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (lfsr_step) begin
            if (step_bad_c) begin
              state <= DONE;
              error <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              seed_q  <= masked_c;
              count_q <= '0;
              state   <= COUNT;
            end
          end
        end
        COUNT: begin
          if (lfsr_step) begin
            count_q <= count_inc_c;
            if (step_bad_c) begin
              state  <= DONE;
              error  <= 1'b1;
              period <= count_inc_c;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else if (match_c) begin
              state   <= DONE;
              period  <= count_inc_c;
              maximal <= maximal_c;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (timeout_c) begin
              state  <= DONE;
              error  <= 1'b1;
              period <= count_inc_c;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
